// File: rtl/piso_feed_311_pkg.sv
// Types and defaults for piso_feed_311, built on the shared define file.
`include "piso_feed_311_defs.vh"

package piso_feed_311_pkg;

    localparam int DEFAULT_WIDTH = `PISO_FEED_311_WIDTH;

    typedef enum logic {
        IDLE  = `PISO_FEED_311_IDLE,
        SHIFT = `PISO_FEED_311_SHIFT
    } state_t;

endpackage

// File: rtl/piso_feed_311_defs.vh
// Shared constants for the piso_feed_311 serializer: FSM state codes and default word width.
`ifndef PISO_FEED_311_DEFS_VH
`define PISO_FEED_311_DEFS_VH

`define PISO_FEED_311_IDLE  1'b0
`define PISO_FEED_311_SHIFT 1'b1
`define PISO_FEED_311_WIDTH 8

`endif

// File: rtl/piso_feed_311.sv
// Parallel-in serial-out feeder: accepts a word on valid/ready and shifts it out one bit per clock,
// with zero-gap back-to-back words and a quiet zero line while idle.
module piso_feed_311
    import piso_feed_311_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_311,
    input  logic             rst_311,
    input  logic [WIDTH-1:0] data_in_311,
    input  logic             valid_311,
    output logic             ready_311,
    output logic             in_311,
    output logic             busy_311,
    output logic             last_311
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] shreg, shreg_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic             in_next, last_next, busy_next;
    logic             accept;

    // Bit that goes on the line next, and the word left after removing it.
    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // Ready during the last bit lets the next word follow with no idle cycle.
    assign ready_311 = (state == IDLE) || last_311;
    assign accept    = valid_311 && ready_311;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        shreg_next = shreg;
        cnt_next   = cnt;
        in_next    = in_311;
        last_next  = last_311;

        if (accept) begin
            state_next = SHIFT;
            shreg_next = advance(data_in_311);
            in_next    = head(data_in_311);
            cnt_next   = '0;
            last_next  = 1'b0;
        end else if (state == SHIFT) begin
            if (last_311) begin
                state_next = IDLE;
                shreg_next = '0;
                cnt_next   = '0;
                in_next    = 1'b0;
                last_next  = 1'b0;
            end else begin
                shreg_next = advance(shreg);
                in_next    = head(shreg);
                cnt_next   = cnt + 1'b1;
                last_next  = (cnt_next == LAST_IDX);
            end
        end

        busy_next = (state_next == SHIFT);
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_311 or negedge rst_311) begin
        if (!rst_311) begin
            state    <= IDLE;
            shreg    <= '0;
            cnt      <= '0;
            in_311   <= 1'b0;
            busy_311 <= 1'b0;
            last_311 <= 1'b0;
        end else begin
            state    <= state_next;
            shreg    <= shreg_next;
            cnt      <= cnt_next;
            in_311   <= in_next;
            busy_311 <= busy_next;
            last_311 <= last_next;
        end
    end

endmodule

// File: tb/tb_piso_feed_311.sv
// Self-checking bench for piso_feed_311: scoreboard of expected serial bits plus directed steps.
module tb_piso_feed_311;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data, data_l;
    logic       valid, valid_l;
    logic       ready, sout, busy, last;
    logic       ready_l, sout_l, busy_l, last_l;

    int errors = 0;
    int checks = 0;
    int hits   = 0;
    bit mon_en = 1'b0;
    logic [2:0] hist = 3'b000;
    logic [1:0] sb[$];

    always #5 clk = ~clk;

    piso_feed_311 #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk_311(clk), .rst_311(rst), .data_in_311(data), .valid_311(valid),
        .ready_311(ready), .in_311(sout), .busy_311(busy), .last_311(last)
    );

    piso_feed_311 #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk_311(clk), .rst_311(rst), .data_in_311(data_l), .valid_311(valid_l),
        .ready_311(ready_l), .in_311(sout_l), .busy_311(busy_l), .last_311(last_l)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: pops one expected {bit,last} per busy cycle; idle line must be quiet and gap-free.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [1:0] e;
            hist = {hist[1:0], sout};
            if (hist == 3'b111) hits++;
            if (busy) begin
                if (sb.size() == 0) begin
                    check("extra_bit", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("serial_bit", 32'(sout), 32'(e[1]));
                    check("last_flag", 32'(last), 32'(e[0]));
                end
            end else begin
                check("idle_line", 32'(sout), 32'd0);
                check("idle_last", 32'(last), 32'd0);
                check("stream_gap", 32'(sb.size()), 32'd0);
            end
        end
    end

    task automatic send(input logic [7:0] w, output int waits);
        bit acc;
        int n;
        data  = w;
        valid = 1'b1;
        waits = 0;
        acc   = 1'b0;
        n     = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            if (ready) begin
                acc = 1'b1;
                if (busy) check("accept_on_last", 32'(last), 32'd1);
            end else begin
                waits++;
            end
            n++;
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
        else for (int i = 7; i >= 0; i--) sb.push_back({w[i], i == 0});
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        int w;
        rst     = 1'b0;
        data    = '0;
        valid   = 1'b0;
        data_l  = '0;
        valid_l = 1'b0;

        // Reset state
        #4;
        check("rst_in", 32'(sout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_last", 32'(last), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        mon_en = 1'b1;
        #4;
        rst = 1'b1;

        // 0xB0 on the first edge after release
        send(8'hB0, w);
        check("b0_waits", 32'(w), 32'd0);
        wait_idle();
        repeat (2) @(negedge clk);

        // Back-to-back 0xE7, 0x3C: ready only on cycles 0 and 8
        @(posedge clk); #1;
        send(8'hE7, w);
        check("e7_waits", 32'(w), 32'd0);
        send(8'h3C, w);
        check("3c_waits", 32'(w), 32'd7);
        wait_idle();

        // 0xFF held while busy; data scrambled while not ready
        @(posedge clk); #1;
        send(8'h96, w);
        for (int i = 0; i < 3; i++) begin
            data = 8'($urandom);
            @(posedge clk); #1;
        end
        send(8'hFF, w);
        check("ff_waits", 32'(w), 32'd4);
        wait_idle();

        // Mid-word asynchronous reset, then a fresh word
        @(posedge clk); #1;
        send(8'hA5, w);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        sb.delete();
        #1;
        check("abort_in", 32'(sout), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_last", 32'(last), 32'd0);
        check("abort_ready", 32'(ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        send(8'h5A, w);
        check("5a_waits", 32'(w), 32'd0);
        wait_idle();

        // LSB-first instance with 0x01
        @(posedge clk); #1;
        data_l  = 8'h01;
        valid_l = 1'b1;
        @(negedge clk);
        check("lsb_ready", 32'(ready_l), 32'd1);
        @(posedge clk); #1;
        valid_l = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("lsb_bit", 32'(sout_l), 32'(i == 0));
            check("lsb_last", 32'(last_l), 32'(i == 7));
        end
        @(negedge clk);
        check("lsb_idle", 32'(busy_l), 32'd0);

        // Overlapping "111" detection on 0x77
        @(posedge clk); #1;
        hits = 0;
        send(8'h77, w);
        wait_idle();
        repeat (2) @(negedge clk);
        check("detect_hits", 32'(hits), 32'd2);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
